// File: rtl/pcs_pkg.sv
// Shared PCS definitions: sync headers, block/SERDES widths, XGMII control
// characters and the 66-bit block payload layout.
package pcs_pkg;

    localparam int unsigned PCS_BLOCK_W = 66;
    localparam int unsigned SERDES_W    = 32;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;

    // Encoded block as presented by the encoder: header in the top two bits.
    typedef struct packed {
        logic [1:0]  sync;
        logic [63:0] payload;
    } pcs_block_t;

    // Line order: header first (bit 64 then 65), then payload LSB first.
    function automatic logic [PCS_BLOCK_W-1:0] pcs_serial_order(input pcs_block_t blk);
        return {blk.payload, blk.sync};
    endfunction

    function automatic logic sync_is_legal(input logic [1:0] sync);
        return (sync == SYNC_DATA) || (sync == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/tx_gearbox_66to32_if.sv
// Encoder-side and SERDES-side handshakes of the 66->32 gearbox plus status.
//   slave  : gearbox view (consumes blocks, produces words and status)
//   master : environment view (offers blocks, consumes words)
interface tx_gearbox_66to32_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    import pcs_pkg::*;

    logic [PCS_BLOCK_W-1:0] encoded_data_in;
    logic                   encoded_valid_in;
    logic                   encoded_ready_out;
    logic [SERDES_W-1:0]    gearbox_data_out;
    logic                   gearbox_valid_out;
    logic                   gearbox_ready_in;
    logic [CNT_WIDTH-1:0]   hdr_err_count;
    logic [7:0]             fill_level;

    modport slave (
        input  encoded_data_in, encoded_valid_in, gearbox_ready_in,
        output encoded_ready_out, gearbox_data_out, gearbox_valid_out,
        output hdr_err_count, fill_level
    );

    modport master (
        output encoded_data_in, encoded_valid_in, gearbox_ready_in,
        input  encoded_ready_out, gearbox_data_out, gearbox_valid_out,
        input  hdr_err_count, fill_level
    );

endinterface

// File: rtl/gearbox_shift_buffer.sv
// Bit-accurate shift buffer: pops OUT_W bits from the bottom and inserts an
// IN_W-bit vector directly above the surviving valid bits, in one cycle.
//   clk, rst : clock, synchronous active-high reset
//   push_i   : insert data_i this cycle (caller guarantees room)
//   pop_i    : drop the bottom OUT_W bits this cycle (caller guarantees cnt >= OUT_W)
//   data_i   : vector to insert, bit 0 oldest
//   word_o   : bottom OUT_W bits of the buffer register
//   cnt_o    : number of valid bits held
module gearbox_shift_buffer #(
    parameter int unsigned IN_W  = 66,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned BUF_W = 128,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [IN_W-1:0]  data_i,
    output logic [OUT_W-1:0] word_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [BUF_W-1:0] sbuf_q, sbuf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] base_c;

    // Bits above cnt stay zero, so the insert can simply OR into place.
    always_comb begin
        sbuf_d = sbuf_q;
        base_c = cnt_q;
        if (pop_i) begin
            sbuf_d = sbuf_q >> OUT_W;
            base_c = cnt_q - CNT_W'(OUT_W);
        end
        cnt_d = base_c;
        if (push_i) begin
            sbuf_d = sbuf_d | (BUF_W'(data_i) << base_c);
            cnt_d  = base_c + CNT_W'(IN_W);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sbuf_q <= '0;
            cnt_q  <= '0;
        end else begin
            sbuf_q <= sbuf_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o = sbuf_q[OUT_W-1:0];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/tx_gearbox_66to32.sv
// 66-bit block to 32-bit word transmit gearbox with sync-header error count.
//   clk : single clock
//   rst : synchronous active-high reset
//   bus : encoded_* block handshake in, gearbox_* word handshake out,
//         hdr_err_count (saturating illegal-header count), fill_level (bits held)
module tx_gearbox_66to32
    import pcs_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    tx_gearbox_66to32_if.slave   bus
);

    localparam int unsigned IN_WIDTH  = PCS_BLOCK_W;
    localparam int unsigned OUT_WIDTH = SERDES_W;
    localparam int unsigned BUF_WIDTH = 128;
    localparam int unsigned FILL_W    = 8;

    localparam logic [FILL_W-1:0] READY_MAX = FILL_W'(BUF_WIDTH - IN_WIDTH);
    localparam logic [FILL_W-1:0] VALID_MIN = FILL_W'(OUT_WIDTH);

    logic [FILL_W-1:0]    fill;
    logic [OUT_WIDTH-1:0] word;
    logic                 ready_c, valid_c, in_fire_c, out_fire_c;
    pcs_block_t           blk_c;
    logic [CNT_WIDTH-1:0] hdr_cnt_q, hdr_cnt_d;

    // Handshakes decoded from the fill register only.
    assign ready_c    = (fill <= READY_MAX);
    assign valid_c    = (fill >= VALID_MIN);
    assign in_fire_c  = bus.encoded_valid_in && ready_c;
    assign out_fire_c = valid_c && bus.gearbox_ready_in;
    assign blk_c      = pcs_block_t'(bus.encoded_data_in);

    gearbox_shift_buffer #(
        .IN_W  (IN_WIDTH),
        .OUT_W (OUT_WIDTH),
        .BUF_W (BUF_WIDTH),
        .CNT_W (FILL_W)
    ) u_shift_buffer (
        .clk    (clk),
        .rst    (rst),
        .push_i (in_fire_c),
        .pop_i  (out_fire_c),
        .data_i (pcs_serial_order(blk_c)),
        .word_o (word),
        .cnt_o  (fill)
    );

    // Saturating count of accepted blocks whose header is 00 or 11.
    always_comb begin
        hdr_cnt_d = hdr_cnt_q;
        if (in_fire_c && !sync_is_legal(blk_c.sync) && (hdr_cnt_q != '1)) begin
            hdr_cnt_d = hdr_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_cnt_q <= '0;
        end else begin
            hdr_cnt_q <= hdr_cnt_d;
        end
    end

    assign bus.encoded_ready_out = ready_c;
    assign bus.gearbox_valid_out = valid_c;
    assign bus.gearbox_data_out  = word;
    assign bus.hdr_err_count     = hdr_cnt_q;
    assign bus.fill_level        = fill;

endmodule

// File: tb/tb_tx_gearbox_66to32.sv
module tb_tx_gearbox_66to32;
    import pcs_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tx_gearbox_66to32_if #(.CNT_WIDTH(16)) gb_if ();
    tx_gearbox_66to32_if #(.CNT_WIDTH(4))  sat_if ();

    tx_gearbox_66to32 #(.CNT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (gb_if.slave)
    );

    // Narrow-counter instance fed the same stimulus, to reach saturation quickly.
    tx_gearbox_66to32 #(.CNT_WIDTH(4)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sat_if.slave)
    );

    typedef struct {
        logic        r_st;
        logic        v;
        logic [65:0] d;
        logic        rdy;
        logic        e_ready;
        logic        e_valid;
        logic [31:0] e_data;
        logic [7:0]  e_fill;
        logic [15:0] e_hdr;
    } vec_t;

    vec_t tv[9];

    int n_vec = 0;
    int n_mis = 0;
    bit mq[$];
    int m_cnt = 0;
    int m_hdr = 0;
    int words_seen = 0;
    int accepted = 0;
    bit saw62 = 0;
    bit saw64 = 0;
    bit saw32 = 0;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word();
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 32; k++) begin
            if (k < mq.size()) w[k] = mq[k];
        end
        return w;
    endfunction

    // One clock: drive, check pre-edge outputs against the model, clock, update model, check.
    task automatic cycle(input logic r_st, input logic v, input logic [65:0] d, input logic rdy);
        logic        in_f, out_f;
        logic [65:0] rv;
        rst = r_st;
        gb_if.encoded_valid_in  = v;
        gb_if.encoded_data_in   = d;
        gb_if.gearbox_ready_in  = rdy;
        sat_if.encoded_valid_in = v;
        sat_if.encoded_data_in  = d;
        sat_if.gearbox_ready_in = rdy;
        chk("ready", 66'(gb_if.encoded_ready_out), 66'(m_cnt <= 62));
        chk("valid", 66'(gb_if.gearbox_valid_out), 66'(m_cnt >= 32));
        chk("data", 66'(gb_if.gearbox_data_out), 66'(model_word()));
        in_f  = !r_st && v && (m_cnt <= 62);
        out_f = !r_st && rdy && (m_cnt >= 32);
        if (!r_st && v && m_cnt == 62) saw62 = 1;
        if (!r_st && v && m_cnt == 64) saw64 = 1;
        if (m_cnt == 32) saw32 = 1;
        if (!r_st && rdy && gb_if.gearbox_valid_out) words_seen++;
        @(posedge clk);
        #1;
        if (r_st) begin
            mq.delete();
            m_cnt = 0;
            m_hdr = 0;
        end else begin
            if (out_f) repeat (32) void'(mq.pop_front());
            if (in_f) begin
                rv = {d[63:0], d[65:64]};
                for (int k = 0; k < 66; k++) mq.push_back(rv[k]);
                accepted++;
                if ((d[65:64] == 2'b00 || d[65:64] == 2'b11) && m_hdr < 65535) m_hdr++;
            end
            m_cnt = m_cnt - (out_f ? 32 : 0) + (in_f ? 66 : 0);
        end
        chk("fill", 66'(gb_if.fill_level), 66'(m_cnt));
        chk("hdr", 66'(gb_if.hdr_err_count), 66'(m_hdr));
        chk("hdr_sat", 66'(sat_if.hdr_err_count), 66'((m_hdr > 15) ? 15 : m_hdr));
    endtask

    task automatic send(input logic [65:0] d);
        int a0;
        a0 = accepted;
        for (int c = 0; c < 10 && accepted == a0; c++) cycle(1'b0, 1'b1, d, 1'b1);
        chk("send_accept", 66'(accepted), 66'(a0 + 1));
    endtask

    task automatic drain();
        for (int c = 0; c < 10 && m_cnt >= 32; c++) cycle(1'b0, 1'b0, '0, 1'b1);
        chk("drain_done", 66'(m_cnt < 32), 66'(1));
    endtask

    initial begin
        logic [1:0] syncs [8];
        logic [65:0] blk;

        tv[0] = '{1'b1, 1'b0, 66'h0,                    1'b0, 1'b1, 1'b0, 32'h0,        8'd0,  16'd0};
        tv[1] = '{1'b0, 1'b1, 66'h1_0123456789ABCDEF,   1'b1, 1'b0, 1'b1, 32'h26AF37BD, 8'd66, 16'd0};
        tv[2] = '{1'b0, 1'b0, 66'h0,                    1'b1, 1'b1, 1'b1, 32'h048D159E, 8'd34, 16'd0};
        tv[3] = '{1'b0, 1'b0, 66'h0,                    1'b1, 1'b1, 1'b0, 32'h0,        8'd2,  16'd0};
        tv[4] = '{1'b0, 1'b1, 66'h3_0000000000000000,   1'b0, 1'b0, 1'b1, 32'h0000000C, 8'd68, 16'd1};
        tv[5] = '{1'b0, 1'b1, 66'h3_0000000000000000,   1'b0, 1'b0, 1'b1, 32'h0000000C, 8'd68, 16'd1};
        tv[6] = '{1'b0, 1'b1, 66'h0_FFFFFFFFFFFFFFFF,   1'b1, 1'b1, 1'b1, 32'h0,        8'd36, 16'd1};
        tv[7] = '{1'b0, 1'b1, 66'h0_FFFFFFFFFFFFFFFF,   1'b1, 1'b0, 1'b1, 32'hFFFFFFC0, 8'd70, 16'd2};
        tv[8] = '{1'b1, 1'b0, 66'h0,                    1'b1, 1'b1, 1'b0, 32'h0,        8'd0,  16'd0};

        rst = 1'b1;
        gb_if.encoded_valid_in  = 1'b0;
        gb_if.encoded_data_in   = '0;
        gb_if.gearbox_ready_in  = 1'b0;
        sat_if.encoded_valid_in = 1'b0;
        sat_if.encoded_data_in  = '0;
        sat_if.gearbox_ready_in = 1'b0;
        @(posedge clk);
        #1;

        // Hand-computed vectors: single block, header error, refusal, mid-stream reset.
        for (int i = 0; i < 9; i++) begin
            cycle(tv[i].r_st, tv[i].v, tv[i].d, tv[i].rdy);
            chk($sformatf("tv%0d_ready", i), 66'(gb_if.encoded_ready_out), 66'(tv[i].e_ready));
            chk($sformatf("tv%0d_valid", i), 66'(gb_if.gearbox_valid_out), 66'(tv[i].e_valid));
            chk($sformatf("tv%0d_data", i),  66'(gb_if.gearbox_data_out),  66'(tv[i].e_data));
            chk($sformatf("tv%0d_fill", i),  66'(gb_if.fill_level),        66'(tv[i].e_fill));
            chk($sformatf("tv%0d_hdr", i),   66'(gb_if.hdr_err_count),     66'(tv[i].e_hdr));
        end

        // 16 back-to-back blocks, downstream always ready: 33 words, bit-exact.
        cycle(1'b1, 1'b0, '0, 1'b1);
        accepted = 0;
        words_seen = 0;
        for (int i = 0; i < 16; i++) begin
            blk = {((i % 2) != 0) ? SYNC_CTRL : SYNC_DATA, 32'hA5C3_0000 | 32'(i), 32'h1234_5678 ^ 32'(i * 7)};
            send(blk);
        end
        drain();
        chk("stream_blocks", 66'(accepted), 66'(16));
        chk("stream_words", 66'(words_seen), 66'(33));
        chk("stream_empty", 66'(gb_if.fill_level), 66'(0));

        // Backpressure from cnt = 62: one more block fills to 128, then refusal.
        cycle(1'b1, 1'b0, '0, 1'b1);
        for (int c = 0; c < 100 && m_cnt != 62; c++) begin
            cycle(1'b0, (m_cnt != 62) && (m_cnt + 34 != 62) && (m_cnt > 62 || m_cnt + 66 <= 128),
                  {SYNC_DATA, 32'(c), ~32'(c)}, 1'b1);
        end
        chk("bp_reach62", 66'(m_cnt), 66'(62));
        accepted = 0;
        for (int c = 0; c < 4; c++) cycle(1'b0, 1'b1, {SYNC_CTRL, 64'hDEAD_BEEF_0000_0000 | 64'(c)}, 1'b0);
        chk("bp_accepted", 66'(accepted), 66'(1));
        chk("bp_fill", 66'(gb_if.fill_level), 66'(128));
        chk("bp_ready", 66'(gb_if.encoded_ready_out), 66'(0));
        words_seen = 0;
        for (int c = 0; c < 10 && m_cnt > 0; c++) cycle(1'b0, 1'b0, '0, 1'b1);
        chk("bp_words", 66'(words_seen), 66'(4));
        chk("bp_empty", 66'(gb_if.fill_level), 66'(0));

        // Mixed legal/illegal headers, then saturate the 4-bit counter.
        cycle(1'b1, 1'b0, '0, 1'b1);
        syncs = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b01, 2'b00, 2'b10};
        for (int i = 0; i < 8; i++) send({syncs[i], $urandom, $urandom});
        drain();
        chk("hdr_mixed", 66'(gb_if.hdr_err_count), 66'(4));
        for (int i = 0; i < 16; i++) send({(i % 2 != 0) ? 2'b11 : 2'b00, $urandom, $urandom});
        drain();
        chk("hdr_wide", 66'(gb_if.hdr_err_count), 66'(20));
        chk("hdr_saturated", 66'(sat_if.hdr_err_count), 66'(4'hF));

        // Reset pulse with fill = 90, then a fresh block passes intact.
        cycle(1'b1, 1'b0, '0, 1'b1);
        for (int c = 0; c < 200 && m_cnt != 90; c++) cycle(1'b0, 1'b1, {SYNC_DATA, $urandom, $urandom}, 1'b1);
        chk("rst_reach90", 66'(gb_if.fill_level), 66'(90));
        cycle(1'b1, 1'b0, '0, 1'b1);
        chk("rst_fill", 66'(gb_if.fill_level), 66'(0));
        chk("rst_valid", 66'(gb_if.gearbox_valid_out), 66'(0));
        chk("rst_ready", 66'(gb_if.encoded_ready_out), 66'(1));
        words_seen = 0;
        send(66'h2_FEDCBA9876543210);
        drain();
        chk("rst_words", 66'(words_seen), 66'(2));

        // Random valid/ready toggling around the thresholds.
        cycle(1'b1, 1'b0, '0, 1'b1);
        for (int c = 0; c < 400; c++) begin
            cycle(1'b0, ($urandom % 4) != 0, {2'($urandom), $urandom, $urandom}, 1'($urandom));
            if (gb_if.fill_level > 8'd128) chk("fill_bound", 66'(gb_if.fill_level), 66'(128));
        end

        chk("boundary_62_seen", 66'(saw62), 66'(1));
        chk("boundary_64_seen", 66'(saw64), 66'(1));
        chk("boundary_32_seen", 66'(saw32), 66'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
